// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU memory bus.
// Used by the memory port arbiter and its round-robin picker.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// On a tie the master that did not go last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       idx
);

    // pick the lone requester, or the non-last one on a tie
    always_comb begin
        valid = |req;
        idx   = req[1];
        if (&req) begin
            idx = ~last;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the CPU and the DMA engine.
// One access per handshake, serialised with 2-way round-robin fairness.
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          last, last_n;
    logic          ack0_n, ack1_n;
    logic [DW-1:0] rdata_n;
    logic          mem_en_n, mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n;
    logic          busy_n, owner_n;
    logic          pick_valid, pick_idx;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // state and every output are registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= M_DMA;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner     <= M_CPU;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last      <= last_n;
            ack0      <= ack0_n;
            ack1      <= ack1_n;
            rdata     <= rdata_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            busy      <= busy_n;
            owner     <= owner_n;
        end
    end

    // next-state and next-output logic: grant, count, complete
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_n      = last;
        ack0_n      = 1'b0;
        ack1_n      = 1'b0;
        rdata_n     = rdata;
        mem_en_n    = mem_en;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        owner_n     = owner;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n     = ACCESS;
                    owner_n     = pick_idx;
                    cnt_n       = 4'(MEM_LAT - 1);
                    mem_en_n    = 1'b1;
                    mem_we_n    = pick_idx ? we1 : we0;
                    mem_addr_n  = pick_idx ? addr1 : addr0;
                    mem_wdata_n = pick_idx ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    state_n  = DONE;
                    mem_en_n = 1'b0;
                    mem_we_n = 1'b0;
                    if (!mem_we) begin
                        rdata_n = mem_rdata;
                    end
                    if (owner) begin
                        ack1_n = 1'b1;
                    end else begin
                        ack0_n = 1'b1;
                    end
                end
            end
            DONE: begin
                last_n  = owner;
                state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                mem_en_n = 1'b0;
                mem_we_n = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Instance u1 runs MEM_LAT=1 vectors, u3 runs MEM_LAT=3 sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [15:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic [15:0] mem_rdata = 0;

    logic        ack0_1, ack1_1, mem_en_1, mem_we_1, busy_1, owner_1;
    logic [15:0] rdata_1, mem_addr_1, mem_wdata_1;
    logic        ack0_3, ack1_3, mem_en_3, mem_we_3, busy_3, owner_3;
    logic [15:0] rdata_3, mem_addr_3, mem_wdata_3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_1),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_1),
        .rdata(rdata_1), .mem_en(mem_en_1), .mem_we(mem_we_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata),
        .busy(busy_1), .owner(owner_1)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_3),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_3),
        .rdata(rdata_3), .mem_en(mem_en_3), .mem_we(mem_we_3),
        .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata),
        .busy(busy_3), .owner(owner_3)
    );

    typedef struct {
        logic        r0, w0;
        logic [15:0] a0, d0;
        logic        r1, w1;
        logic [15:0] a1, d1, mrd;
        logic        e_ack0, e_ack1, e_en, e_we;
        logic [15:0] e_addr, e_wd, e_rd;
        logic        e_busy, e_own;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
        logic r1, logic w1, logic [15:0] a1, logic [15:0] d1,
        logic [15:0] mrd,
        logic k0, logic k1, logic en, logic we,
        logic [15:0] ad, logic [15:0] wd, logic [15:0] rd,
        logic bz, logic ow);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.mrd = mrd;
        v.e_ack0 = k0; v.e_ack1 = k1; v.e_en = en; v.e_we = we;
        v.e_addr = ad; v.e_wd = wd; v.e_rd = rd;
        v.e_busy = bz; v.e_own = ow;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        tick();
        tick();
        chk("reset_u1", {ack0_1, ack1_1, mem_en_1, mem_we_1, mem_addr_1,
                         mem_wdata_1, rdata_1, busy_1, owner_1}, 64'd0);
        chk("reset_u3", {ack0_3, ack1_3, mem_en_3, mem_we_3, mem_addr_3,
                         mem_wdata_3, rdata_3, busy_3, owner_3}, 64'd0);
        reset = 1'b0;
    endtask

    task automatic drive(logic m, logic r, logic w, logic [15:0] a, logic [15:0] d);
        if (m) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic txn3(logic m, logic w, logic [15:0] a, logic [15:0] d,
                        logic [15:0] mrd, logic [15:0] exp_rd);
        drive(m, 1'b1, w, a, d);
        mem_rdata = mrd;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("txn_access", {mem_en_3, mem_we_3, mem_addr_3, mem_wdata_3,
                               ack0_3, ack1_3, owner_3},
                {1'b1, w, a, d, 1'b0, 1'b0, m});
        end
        tick();
        chk("txn_ack", {ack0_3, ack1_3, mem_en_3, mem_we_3, rdata_3},
            {~m, m, 1'b0, 1'b0, exp_rd});
        drive(m, 1'b0, w, a, d);
        tick();
        chk("txn_idle", {busy_3, ack0_3, ack1_3}, 3'b000);
    endtask

    task automatic wait_ack3(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ack0_3 | ack1_3) && n < 12);
    endtask

    initial begin
        int n;
        int last_cyc;

        tbl[0]  = mk(1,0,16'h0040,0, 0,0,0,0, 16'hBEEF, 0,0,1,0,16'h0040,0,16'h0000,1,0);
        tbl[1]  = mk(1,0,16'h0040,0, 0,0,0,0, 16'hBEEF, 1,0,0,0,16'h0040,0,16'hBEEF,1,0);
        tbl[2]  = mk(0,0,16'h0040,0, 0,0,0,0, 16'hBEEF, 0,0,0,0,16'h0040,0,16'hBEEF,0,0);
        tbl[3]  = mk(0,0,16'h0040,0, 0,0,0,0, 16'hBEEF, 0,0,0,0,16'h0040,0,16'hBEEF,0,0);
        tbl[4]  = mk(0,0,0,0, 1,1,16'h0200,16'h5555, 16'hBEEF,
                     0,0,1,1,16'h0200,16'h5555,16'hBEEF,1,1);
        tbl[5]  = mk(0,0,0,0, 1,1,16'h0200,16'h5555, 16'hBEEF,
                     0,1,0,0,16'h0200,16'h5555,16'hBEEF,1,1);
        tbl[6]  = mk(0,0,0,0, 0,1,16'h0200,16'h5555, 16'hBEEF,
                     0,0,0,0,16'h0200,16'h5555,16'hBEEF,0,1);
        tbl[7]  = mk(1,0,16'h0041,0, 1,0,16'h0300,0, 16'h1111,
                     0,0,1,0,16'h0041,0,16'hBEEF,1,0);
        tbl[8]  = mk(1,0,16'h0041,0, 1,0,16'h0300,0, 16'h1111,
                     1,0,0,0,16'h0041,0,16'h1111,1,0);
        tbl[9]  = mk(0,0,16'h0041,0, 1,0,16'h0300,0, 16'h2222,
                     0,0,0,0,16'h0041,0,16'h1111,0,0);
        tbl[10] = mk(0,0,16'h0041,0, 1,0,16'h0300,0, 16'h2222,
                     0,0,1,0,16'h0300,0,16'h1111,1,1);
        tbl[11] = mk(0,0,16'h0041,0, 1,0,16'h0300,0, 16'h2222,
                     0,1,0,0,16'h0300,0,16'h2222,1,1);
        tbl[12] = mk(0,0,16'h0041,0, 0,0,16'h0300,0, 16'h2222,
                     0,0,0,0,16'h0300,0,16'h2222,0,1);

        do_reset();

        for (int i = 0; i < 13; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0;
            addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1;
            addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            mem_rdata = tbl[i].mrd;
            tick();
            chk($sformatf("vec%0d", i),
                {ack0_1, ack1_1, mem_en_1, mem_we_1, mem_addr_1,
                 mem_wdata_1, rdata_1, busy_1, owner_1},
                {tbl[i].e_ack0, tbl[i].e_ack1, tbl[i].e_en, tbl[i].e_we,
                 tbl[i].e_addr, tbl[i].e_wd, tbl[i].e_rd,
                 tbl[i].e_busy, tbl[i].e_own});
        end

        do_reset();
        txn3(1'b0, 1'b0, 16'h0050, 16'h0000, 16'hCAFE, 16'hCAFE);
        txn3(1'b1, 1'b1, 16'h0100, 16'h1234, 16'hDEAD, 16'hCAFE);

        do_reset();
        drive(1'b0, 1'b1, 1'b0, 16'h0A00, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'h0B00, 16'h0000);
        tick();
        chk("tie_first_owner", {busy_3, owner_3}, 2'b10);
        last_cyc = 0;
        for (int t = 0; t < 4; t++) begin
            wait_ack3(n);
            chk($sformatf("fair_ack%0d", t), {ack0_3, ack1_3},
                (t % 2 == 1) ? 2'b01 : 2'b10);
            if (t > 0) begin
                chk($sformatf("fair_gap%0d", t), 64'(cyc - last_cyc), 64'd5);
            end
            last_cyc = cyc;
        end
        req0 = 0; req1 = 0;
        tick();
        tick();

        do_reset();
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        mem_rdata = 16'h3333;
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        tick();
        tick();
        tick();
        chk("late_ack0", {ack0_3, ack1_3, rdata_3}, {2'b10, 16'h3333});
        req0 = 0;
        tick();
        chk("late_idle", {busy_3, ack0_3, ack1_3}, 3'b000);
        tick();
        chk("late_grant1", {mem_en_3, owner_3, mem_addr_3}, {2'b11, 16'h0020});
        tick();
        tick();
        tick();
        chk("late_ack1", {ack0_3, ack1_3}, 2'b01);
        req1 = 0;
        tick();

        do_reset();
        drive(1'b0, 1'b1, 1'b0, 16'h0070, 16'h0000);
        mem_rdata = 16'h7777;
        tick();
        chk("rst_mid_access", {mem_en_3, busy_3}, 2'b11);
        reset = 1'b1;
        tick();
        chk("rst_mid_clear", {busy_3, mem_en_3, ack0_3, ack1_3, mem_addr_3},
            {4'b0000, 16'h0000});
        reset = 1'b0;
        req0 = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_no_ack", {busy_3, ack0_3, ack1_3}, 3'b000);
        end
        txn3(1'b0, 1'b0, 16'h0071, 16'h0000, 16'h7777, 16'h7777);

        do_reset();
        drive(1'b0, 1'b1, 1'b0, 16'h0090, 16'h0000);
        mem_rdata = 16'h9999;
        tick();
        req0 = 0;
        tick();
        tick();
        tick();
        chk("drop_ack", {ack0_3, ack1_3, rdata_3}, {2'b10, 16'h9999});
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drop_idle", {busy_3, ack0_3, ack1_3, mem_en_3}, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between two bus masters.
- Master 0 is the CPU fetch/execute controller (MAR/MDR path); master 1 is a DMA/IO engine.
- Each master issues one read or write per request/acknowledge handshake; the arbiter serialises them with 2-way round-robin fairness.
- Sits between the masters and the memory; the masters never drive the memory directly.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 1, memory access cycles (mem_en held for this many cycles; read data valid in the last one). Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- req0  in  1  master 0 request; held high until ack0.
- we0  in  1  master 0 write (1) / read (0); stable while req0.
- addr0  in  AW  master 0 address; stable while req0.
- wdata0  in  DW  master 0 write data; stable while req0.
- ack0  out  1  one-cycle completion pulse to master 0.
- req1, we1, addr1, wdata1, ack1: as above, for master 1.
- rdata  out  DW  read data, valid while the ack of a read is high; holds its value otherwise.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  index of the granted master; meaningful while busy.

Behaviour:
- All outputs registered.
- Reset values: ack0=ack1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, owner=0, state=IDLE, last_owner=1.
  - last_owner=1 means master 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only reqN high: grant N.
  - Both high: grant the master that is not last_owner.
  - On grant: latch the granted master's addr/wdata/we into the mem_* registers, set owner, load cnt=MEM_LAT-1, go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_we=latched we for exactly MEM_LAT cycles; mem_addr/mem_wdata constant.
  - Each cycle: if cnt!=0, decrement cnt.
  - If cnt==0: on a read, capture mem_rdata into rdata; go to DONE.
- DONE:
  - mem_en=0, mem_we=0; ack[owner]=1 for exactly this one cycle.
  - last_owner<=owner; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 -> mem_en high in cycles 1..MEM_LAT -> ack high in cycle MEM_LAT+1.
  - Back-to-back transactions: one every MEM_LAT+2 cycles.
- Handshake rules:
  - The master drops req on the edge that ends its ack cycle, so IDLE samples it low.
  - A master may raise a new request immediately after that.
  - Requests arriving while busy wait; they are not lost and not queued beyond the level-held req.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1...
- Boundary conditions:
  - Req withdrawn before ack (protocol violation): the transaction still completes and ack is still issued. No abort.
  - Both masters request the same address: no special handling; accesses are serialised in grant order.
  - Reset mid-transaction: next cycle is IDLE with reset values; no ack issued; mem_en low; the pending access is abandoned.
  - MEM_LAT=1: ACCESS lasts exactly one cycle; cnt is unused.
  - For writes, rdata is unchanged.

Decomposition:
- Shared package (cpu_bus_pkg):
  - state enum {IDLE, ACCESS, DONE}.
  - Constants M_CPU=0, M_DMA=1.
  - Default AW/DW widths.
- One natural sub-module: rr_pick2. Combinational 2-way round-robin picker with inputs req[1:0] and last; outputs valid and idx. Instantiated once in IDLE grant logic.

Test Plan:
- Single read, MEM_LAT=1: req0=1, we0=0, addr0=16'h0040, memory returns 16'hBEEF -> mem_en/mem_addr=0040 in cycle 1, ack0 in cycle 2 with rdata=BEEF, ack1 never high.
- Single write, MEM_LAT=3: req1=1, we1=1, addr1=16'h0100, wdata1=16'h1234 -> mem_en=mem_we=1 for cycles 1-3 with addr 0100 / data 1234, ack1 in cycle 4, rdata unchanged.
- Tie after reset: req0 and req1 rise together -> first grant owner=0; with both held, grants alternate 0,1,0,1 over 4 transactions, ack spacing MEM_LAT+2.
- Late arrival: req0 granted; req1 raised during ACCESS -> req1 is granted in the IDLE cycle right after ack0, with no loss.
- Reset mid-operation: assert reset in cycle 1 of a MEM_LAT=3 read -> next cycle busy=0, mem_en=0; no ack ever; subsequent req0 is served normally.
- Early req drop: req0 drops in ACCESS -> ack0 still pulses once; arbiter returns to IDLE and stays idle.
